// File: rtl/aibcr3_ddr_serializer.sv
// Multi-lane parallel-to-DDR serializer for the AIB transmit path.
// Holding register feeds a per-lane shifter; two bits per lane per clock.
module aibcr3_ddr_serializer #(
  parameter int   LANES     = 1,
  parameter int   RATIO     = 4,
  parameter logic IDLE_EVEN = 1'b0,
  parameter logic IDLE_ODD  = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ser_en,
  input  logic [LANES*2*RATIO-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [LANES-1:0]         dout,
  output logic                     busy,
  output logic                     underflow
);

  localparam int W  = LANES * 2 * RATIO;
  localparam int CW = (RATIO > 2) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

  logic [W-1:0]     hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [W-1:0]     shift_q, shift_d;
  logic             sh_full_q, sh_full_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [LANES-1:0] even_q, even_d;
  logic [LANES-1:0] odd_q, odd_d;
  logic             busy_q, busy_d;
  logic             uflow_q, uflow_d;
  logic             rdy_en_q;

  logic             ready;
  logic             accept;
  logic             emit;
  logic             last;
  logic             load;
  logic [LANES-1:0] beat_even;
  logic [LANES-1:0] beat_odd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      sh_full_q   <= 1'b0;
      cnt_q       <= '0;
      even_q      <= {LANES{IDLE_EVEN}};
      odd_q       <= {LANES{IDLE_ODD}};
      busy_q      <= 1'b0;
      uflow_q     <= 1'b0;
      rdy_en_q    <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      sh_full_q   <= sh_full_d;
      cnt_q       <= cnt_d;
      even_q      <= even_d;
      odd_q       <= odd_d;
      busy_q      <= busy_d;
      uflow_q     <= uflow_d;
      rdy_en_q    <= 1'b1;
    end
  end

  // The shifter consumes its low two bits per lane every emitted beat.
  always_comb begin
    beat_even = '0;
    beat_odd  = '0;
    for (int l = 0; l < LANES; l++) begin
      beat_even[l] = shift_q[l*2*RATIO];
      beat_odd[l]  = shift_q[l*2*RATIO+1];
    end
  end

  always_comb begin
    ready  = rdy_en_q & ser_en & ~hold_full_q;
    accept = in_valid & ready;
    emit   = sh_full_q;
    last   = emit & (cnt_q == LAST);
    load   = hold_full_q & (~sh_full_q | last);
  end

  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    sh_full_d   = sh_full_q;
    cnt_d       = cnt_q;
    even_d      = {LANES{IDLE_EVEN}};
    odd_d       = {LANES{IDLE_ODD}};
    busy_d      = 1'b0;
    uflow_d     = 1'b0;
    if (!ser_en) begin
      hold_full_d = 1'b0;
      sh_full_d   = 1'b0;
      cnt_d       = '0;
    end else begin
      if (accept) begin
        hold_d = in_data;
      end
      hold_full_d = accept | (hold_full_q & ~load);
      if (emit) begin
        even_d    = beat_even;
        odd_d     = beat_odd;
        busy_d    = 1'b1;
        shift_d   = shift_q >> 2;
        sh_full_d = ~last;
        cnt_d     = last ? '0 : cnt_q + 1'b1;
      end else begin
        uflow_d = busy_q;
      end
      if (load) begin
        shift_d   = hold_q;
        sh_full_d = 1'b1;
        cnt_d     = '0;
      end
    end
  end

  // High phase carries the odd bit, low phase the even bit.
  always_comb begin
    in_ready  = ready;
    busy      = busy_q;
    underflow = uflow_q;
    dout      = clk ? odd_q : even_q;
  end

endmodule

// File: doc/aibcr3_ddr_serializer.md
Name: aibcr3_ddr_serializer

Overview:
- Parametrised multi-lane parallel-to-DDR serializer for the AIB transmit datapath.
- Accepts a parallel word through a valid/ready handshake and buffers it in a holding register plus a per-lane shift register.
- Drives 2 bits per lane per clock: even bit while clk low, odd bit while clk high.
- Streams back-to-back words without bubbles; drives a programmable idle pattern when starved.

Parameters:
LANES, 1, number of independent serial output lanes
RATIO, 4, clock cycles per word per lane; each lane carries 2*RATIO bits per word (RATIO >= 1)
IDLE_EVEN, 1'b0, bit driven in the low phase when no data is active
IDLE_ODD, 1'b0, bit driven in the high phase when no data is active

Ports:
clk  input  1  transmit clock; also the DDR phase select
rst_n  input  1  asynchronous active-low reset
ser_en  input  1  serializer enable; low = synchronous flush to idle
in_data  input  LANES*2*RATIO  parallel word; lane l occupies bits [l*2*RATIO +: 2*RATIO]
in_valid  input  1  in_data is valid
in_ready  output  1  holding register can accept a word
dout  output  LANES  DDR serial output per lane
busy  output  1  shift register holds an active word
underflow  output  1  one-cycle pulse on the first idle cycle after active data while ser_en=1

Behaviour:
- Reset (rst_n low, asynchronous):
  - Holding register and shift register are empty; beat counter = 0.
  - even_q/odd_q = IDLE_EVEN/IDLE_ODD.
  - in_ready, busy and underflow all = 0.
- Reset release: in_ready follows the ready rule below from the first rising edge.
- Ready rule:
  - in_ready = ser_en & !hold_full.
  - Combinational from registered state only; there is no path from in_valid to in_ready.
- Accept: a word is taken at the rising edge where in_valid & in_ready; hold_full is set.
- Load (hold to shift register) happens at a rising edge when hold_full and either the shifter is empty or the counter = RATIO-1.
  - Load clears hold_full, unless a new word is accepted in the same cycle.
  - Accept and load in the same cycle keeps hold_full = 1 with the new word.
- Beat k (counter = k) of lane l:
  - even_q[l] = word[l*2*RATIO + 2k]
  - odd_q[l] = word[l*2*RATIO + 2k + 1]
  - Bits go out LSB first.
  - even_q/odd_q are registered on the rising edge.
- Output: dout[l] = clk ? odd_q[l] : even_q[l].
  - The odd bit appears in the high phase right after the edge; the even bit appears in the following low phase.
  - Per-lane mux cell behaviour matches the existing DDR mux cell: the high phase selects the in1/odd input.
- Latency:
  - A word accepted at edge N loads at edge N+1 if the shifter is empty.
  - Its beat 0 odd bit drives dout in the high phase after edge N+2.
- Counter:
  - Increments each active cycle and wraps RATIO-1 -> 0.
  - With RATIO=1 every active cycle is a load cycle.
  - Counter width is clog2(max(RATIO,2)).
- busy = 1 from a load until the last beat completes with no follow-on load.
- Starvation: at counter = RATIO-1 with hold empty, the next edge:
  - sets even_q/odd_q to idle;
  - clears busy;
  - pulses underflow high for exactly one cycle.
- ser_en low, sampled at an edge:
  - hold and shifter are flushed;
  - counter = 0;
  - outputs go idle;
  - no underflow pulse is generated;
  - the in_data of a cycle where in_ready was high is still accepted, then flushed if ser_en is low at the following edge.
- ser_en high again: normal operation resumes from empty.
- in_valid high while in_ready is low: no effect; data must be held by the source.
- Mid-operation reset: asynchronously returns to the reset state; the partial word is discarded.

Test Plan:
- LANES=1, RATIO=4: reset, then send word 8'b1011_0010 -> from edge N+2, dout high/low phases carry (odd,even) = (1,0),(0,0),(1,1),(1,0); busy high for 4 cycles; underflow pulses once; dout then idle 0.
- Streaming 3 words back-to-back with in_valid held high -> no idle beats between words; in_ready toggles 1,0,1 per word; underflow only after the third word.
- LANES=2, RATIO=2, in_data=8'hA5 -> lane0 (even,odd) = (1,0),(1,0); lane1 = (0,1),(0,1).
- ser_en dropped at beat 1 of a word -> next edge outputs idle, busy=0, in_ready=0, no underflow; ser_en re-raised -> new word serializes from beat 0.
- rst_n asserted mid-word (between edges) -> dout immediately idle, in_ready/busy/underflow 0; after release a fresh word serializes correctly.
- RATIO=1, IDLE_EVEN=1, IDLE_ODD=0, with gaps between words -> each word takes 1 cycle; idle low phases drive 1 and idle high phases drive 0; one underflow pulse per gap.
